// File: rtl/fifo_out_if.sv
// rtl/fifo_out_if.sv - push/pop handshake and status bundle for the output FIFO
interface fifo_out_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  full;
    logic                  empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;

    modport master (
        output wr_en, din, rd_en,
        input  dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/fifo_out.sv
// rtl/fifo_out.sv - result FIFO from factorial core to host, five-state operation FSM
module fifo_out #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    fifo_out_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        WRITE    = 3'b001,
        READ     = 3'b010,
        WR_ERROR = 3'b011,
        RD_ERROR = 3'b100
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  wr_ack_q;
    logic                  wr_err_q;
    logic                  rd_ack_q;
    logic                  rd_err_q;
    logic                  push_ok;

    assign push_ok = bus.wr_en && !bus.rd_en && (count != FULL_COUNT);

    // Storage has no reset; the reset gate keeps a push from landing while reset is held.
    always_ff @(posedge clk) begin
        if (push_ok && reset_n) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            case ({bus.wr_en, bus.rd_en})
                2'b10: begin
                    if (count != FULL_COUNT) begin
                        state    <= WRITE;
                        wr_ptr   <= wr_ptr + 1'b1;
                        count    <= count + 1'b1;
                        wr_ack_q <= 1'b1;
                    end else begin
                        state    <= WR_ERROR;
                        wr_err_q <= 1'b1;
                    end
                end
                2'b01: begin
                    if (count != '0) begin
                        state    <= READ;
                        dout_q   <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + 1'b1;
                        count    <= count - 1'b1;
                        rd_ack_q <= 1'b1;
                    end else begin
                        state    <= RD_ERROR;
                        rd_err_q <= 1'b1;
                    end
                end
                2'b00: state <= IDLE;
                default: begin
                    // Simultaneous push and pop is a no-op that holds a legal state.
                    case (state)
                        IDLE, WRITE, READ, WR_ERROR, RD_ERROR: state <= state;
                        default:                               state <= IDLE;
                    endcase
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_count = count;
    assign bus.full       = (count == FULL_COUNT);
    assign bus.empty      = (count == '0);
    assign bus.wr_ack     = wr_ack_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_fifo_out.sv
// tb/tb_fifo_out.sv - directed self-checking bench for fifo_out
module tb_fifo_out;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fifo_out_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    fifo_out #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din = '0;
        #12;
        checks++;
        if (bus.data_count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status count=%0d empty=%b full=%b want 0 1 0", bus.data_count, bus.empty, bus.full);
        end
        checks++;
        if ({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err} !== 4'b0 || bus.dout !== 32'h0 || 3'(dut.state) !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs flags=%b dout=%h state=%0d want 0000 0 0",
                     {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, bus.dout, 3'(dut.state));
        end
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            bus.din = 32'((i + 1) * 'h11);
            step();
            checks++;
            if (bus.wr_ack !== 1'b1 || bus.data_count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_%0d wr_ack=%b count=%0d want 1 %0d", i, bus.wr_ack, bus.data_count, i + 1);
            end
        end
        checks++;
        if (bus.full !== 1'b1 || 3'(dut.state) !== 3'b001) begin
            errors++;
            $display("FAIL fill_full full=%b state=%0d want 1 1", bus.full, 3'(dut.state));
        end
    endtask

    task automatic test_overflow();
        bus.wr_en = 1'b1;
        bus.din = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.wr_err !== 1'b1 || bus.wr_ack !== 1'b0 || bus.data_count !== 4'd8 || 3'(dut.state) !== 3'b011) begin
                errors++;
                $display("FAIL overflow_%0d wr_err=%b wr_ack=%b count=%0d state=%0d want 1 0 8 3",
                         i, bus.wr_err, bus.wr_ack, bus.data_count, 3'(dut.state));
            end
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_drain();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.rd_ack !== 1'b1 || bus.dout !== 32'((i + 1) * 'h11) || bus.data_count !== 4'(7 - i)) begin
                errors++;
                $display("FAIL drain_%0d rd_ack=%b dout=%h count=%0d want 1 %h %0d",
                         i, bus.rd_ack, bus.dout, bus.data_count, 32'((i + 1) * 'h11), 7 - i);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty empty=%b want 1", bus.empty);
        end
    endtask

    task automatic test_underflow();
        bus.rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.rd_err !== 1'b1 || bus.rd_ack !== 1'b0 || bus.dout !== 32'h88 ||
                bus.data_count !== 4'd0 || 3'(dut.state) !== 3'b100) begin
                errors++;
                $display("FAIL underflow_%0d rd_err=%b rd_ack=%b dout=%h count=%0d state=%0d want 1 0 88 0 4",
                         i, bus.rd_err, bus.rd_ack, bus.dout, bus.data_count, 3'(dut.state));
            end
        end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        bus.din = 32'h5;
        step();
        bus.wr_en = 1'b0;
        checks++;
        if (3'(dut.state) !== 3'b001 || bus.data_count !== 4'd1 || bus.wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL recover_push state=%0d count=%0d wr_ack=%b want 1 1 1", 3'(dut.state), bus.data_count, bus.wr_ack);
        end
    endtask

    task automatic test_wrap();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.din = 32'h100 + 32'(i);
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.rd_ack !== 1'b1 || bus.dout !== 32'h100 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_pop_a%0d rd_ack=%b dout=%h want 1 %h", i, bus.rd_ack, bus.dout, 32'h100 + 32'(i));
            end
        end
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din = 32'h200 + 32'(i);
            step();
        end
        bus.wr_en = 1'b0;
        checks++;
        if (dut.wr_ptr !== 3'd3 || bus.data_count !== 4'd5) begin
            errors++;
            $display("FAIL wrap_wr_ptr wr_ptr=%0d count=%0d want 3 5", dut.wr_ptr, bus.data_count);
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.rd_ack !== 1'b1 || bus.dout !== 32'h200 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_pop_b%0d rd_ack=%b dout=%h want 1 %h", i, bus.rd_ack, bus.dout, 32'h200 + 32'(i));
            end
        end
        bus.rd_en = 1'b0;
        step();
        checks++;
        if (dut.wr_ptr !== 3'd3 || dut.rd_ptr !== 3'd3 || bus.data_count !== 4'd0 || 3'(dut.state) !== 3'b000) begin
            errors++;
            $display("FAIL wrap_end wr_ptr=%0d rd_ptr=%0d count=%0d state=%0d want 3 3 0 0",
                     dut.wr_ptr, dut.rd_ptr, bus.data_count, 3'(dut.state));
        end
    endtask

    task automatic test_both();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.din = 32'h300 + 32'(i);
            step();
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.data_count !== 4'd4 || {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err} !== 4'b0 ||
                3'(dut.state) !== 3'b001) begin
                errors++;
                $display("FAIL both_%0d count=%0d flags=%b state=%0d want 4 0000 1",
                         i, bus.data_count, {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 3'(dut.state));
            end
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        step();
        checks++;
        if (3'(dut.state) !== 3'b000 || bus.data_count !== 4'd4) begin
            errors++;
            $display("FAIL both_release state=%0d count=%0d want 0 4", 3'(dut.state), bus.data_count);
        end
    endtask

    task automatic test_async_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din = 32'h400 + 32'(i);
            step();
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.data_count !== 4'd0 || bus.dout !== 32'h0 || 3'(dut.state) !== 3'b000 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset count=%0d dout=%h state=%0d empty=%b want 0 0 0 1",
                     bus.data_count, bus.dout, 3'(dut.state), bus.empty);
        end
        #1;
        reset_n = 1'b1;
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_err !== 1'b1 || bus.rd_ack !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_pop rd_err=%b rd_ack=%b want 1 0", bus.rd_err, bus.rd_ack);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_wrap();
        test_both();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
